phys_reg_free_list: RTL
=======================

Name: phys_reg_free_list

Overview:
- Circular FIFO of unallocated physical register indices. It feeds the rename stage that writes new entries into the reorder buffer.
- Rename pops one index per instruction for its new dest_reg.
- The reorder buffer pushes indices back:
  - on retire, the entry's old_dest_reg;
  - on rollback, the entry's dest_reg.
- Physical register 0 is the hardwired x0 mapping and is never stored.

Parameters:
- PHYS_ADDR_WIDTH, 7, width of a physical register index (2^7 = 128 physical registers).
- ARCH_REGS, 32, number of architectural registers, identity-mapped at reset.
- DEPTH (localparam), 2^PHYS_ADDR_WIDTH - ARCH_REGS = 96, maximum number of free entries.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- alloc_req  input  1  rename requests one register this cycle.
- alloc_valid  output  1  list non-empty; alloc_reg is meaningful.
- alloc_reg  output  PHYS_ADDR_WIDTH  index at list head.
- free_en  input  1  return free_reg to the list this cycle.
- free_reg  input  PHYS_ADDR_WIDTH  index being returned.
- free_count  output  PHYS_ADDR_WIDTH+1  number of entries held.
- empty  output  1  free_count == 0.
- full  output  1  free_count == DEPTH.
- overflow_error  output  1  sticky; a free was dropped because the list was full.

Behaviour:
- Storage:
  - mem[DEPTH] of PHYS_ADDR_WIDTH bits.
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping explicitly from DEPTH-1 to 0 (DEPTH need not be a power of two).
  - count register.
- Reset (synchronous, takes priority over everything, including mid-operation requests):
  - mem[i] = ARCH_REGS + i for i in 0..DEPTH-1.
  - head = 0, tail = 0, count = DEPTH.
  - overflow_error = 0.
  - Resulting outputs: full = 1, empty = 0, alloc_valid = 1, alloc_reg = 32, free_count = 96.
- Reads are combinational, zero-latency:
  - alloc_reg = mem[head].
  - alloc_valid = (count != 0).
  - empty, full and free_count derive from count.
- Allocation fires when alloc_req && alloc_valid; on fire, head advances next edge.
  - alloc_req while empty is ignored, with no state change; rename must stall on !alloc_valid.
- Free accepted when free_en && free_reg != 0, subject to the full rule below.
  - On accept: mem[tail] <= free_reg and tail advances.
  - free_reg == 0 is silently ignored: no write, no error.
- count next = count + accepted_free - alloc_fire.
- Simultaneous events:
  - Alloc fire and accepted free in the same cycle: both occur; count unchanged.
  - Full with free_en (nonzero) and alloc fire in the same cycle: the free is accepted (slot vacated); no error.
  - Full with free_en (nonzero) and no alloc fire: the free is dropped, overflow_error <= 1 (sticky until reset), state unchanged.
  - Empty with free_en: write accepted, but there is no bypass; alloc_valid stays 0 that cycle and rises on the next cycle.
- Wrap-around: pointers roll DEPTH-1 -> 0. Data order is strict FIFO across the wrap.
- No double-free detection; upstream guarantees uniqueness.
- At most one alloc and one free per cycle. Retire and rollback frees are mutually exclusive in the reorder buffer, so a single free port suffices.

Decomposition:
- Shared package rv32_sched_pkg holds:
  - PHYS_ADDR_WIDTH and ARCH_REGS constants;
  - typedef phys_reg_t (logic [PHYS_ADDR_WIDTH-1:0]), shared with the reorder buffer entry's dest_reg/old_dest_reg fields.
- One natural sub-module: wrap_counter, a modulo-DEPTH pointer with an increment enable, instantiated twice (head, tail).
- Count and error logic stay in the top level.

Test Plan:
1. Reset, then idle: alloc_reg = 32, alloc_valid = 1, free_count = 96, full = 1, empty = 0, overflow_error = 0.
2. Hold alloc_req for 96 cycles: alloc_reg sequence is 32..127; afterwards empty = 1, alloc_valid = 0. A 97th alloc_req causes no change.
3. From empty, free_en with free_reg = 45 in cycle N: alloc_valid = 0 in cycle N, then 1 with alloc_reg = 45 in N+1, free_count = 1.
4. From reset, pop 1, then in one cycle assert alloc_req plus free_en (free_reg = 7): free_count stays 95, and 7 emerges after 95 further pops (FIFO order across tail wrap).
5. Full list:
   - free_en with free_reg = 9 and no alloc: overflow_error = 1 and stays 1, count = 96.
   - Same with alloc_req: accepted, no error.
6. Miscellaneous:
   - free_reg = 0 with free_en: count unchanged, no error.
   - Assert reset mid-stream after 20 pops: next cycle shows the test 1 values.

Source files
------------

// File: rtl/rv32_sched_pkg.sv
// Shared scheduler types and sizing constants for the rename / reorder-buffer slice.
// phys_reg_t is the same type the reorder buffer uses for dest_reg and old_dest_reg.
package rv32_sched_pkg;

  localparam int PHYS_ADDR_WIDTH = 7;
  localparam int ARCH_REGS       = 32;
  localparam int FREE_LIST_DEPTH = (1 << PHYS_ADDR_WIDTH) - ARCH_REGS;

  typedef logic [PHYS_ADDR_WIDTH-1:0] phys_reg_t;

  // A pointer always has at least one bit, even for a degenerate one-entry list.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_wrap_counter.sv
// Modulo-DEPTH pointer with an increment enable; wraps DEPTH-1 -> 0 explicitly,
// so DEPTH does not have to be a power of two.
module wrap_counter #(
  parameter int DEPTH = 96,
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of unallocated physical register indices feeding rename.
// Register 0 (x0) is never stored; the list starts full with ARCH_REGS..2^W-1.
module phys_reg_free_list #(
  parameter int PHYS_ADDR_WIDTH = 7,
  parameter int ARCH_REGS       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alloc_req,
  output logic                       alloc_valid,
  output logic [PHYS_ADDR_WIDTH-1:0] alloc_reg,
  input  logic                       free_en,
  input  logic [PHYS_ADDR_WIDTH-1:0] free_reg,
  output logic [PHYS_ADDR_WIDTH:0]   free_count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow_error
);

  import rv32_sched_pkg::*;

  localparam int DEPTH   = (1 << PHYS_ADDR_WIDTH) - ARCH_REGS;
  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int COUNT_W = PHYS_ADDR_WIDTH + 1;

  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DEPTH);

  logic [PHYS_ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]           head;
  logic [PTR_W-1:0]           tail;
  logic [COUNT_W-1:0]         count;

  logic alloc_fire;
  logic free_valid;
  logic free_accept;
  logic free_drop;
  logic is_full;

  // Handshake: alloc_valid/alloc_reg are combinational from the head entry; an
  // allocation completes on a rising edge where alloc_req && alloc_valid, and the
  // head advances on that edge. alloc_req with alloc_valid low is ignored and
  // rename must stall. free_en is a one-cycle push with no back-pressure: a
  // nonzero index is taken unless the list is full with no allocation in the
  // same cycle, in which case it is dropped and overflow_error latches.
  always_comb begin
    is_full     = (count == COUNT_FULL);
    alloc_valid = (count != '0);
    alloc_reg   = mem[head];
    free_count  = count;
    empty       = (count == '0);
    full        = is_full;
  end

  always_comb begin
    alloc_fire  = alloc_req && alloc_valid;
    free_valid  = free_en && (free_reg != '0);
    // An allocation in the same cycle vacates a slot, so a full list can still take the free.
    free_accept = free_valid && (!is_full || alloc_fire);
    free_drop   = free_valid && is_full && !alloc_fire;
  end

  wrap_counter #(
    .DEPTH (DEPTH),
    .WIDTH (PTR_W)
  ) u_head (
    .clock (clock),
    .reset (reset),
    .inc   (alloc_fire),
    .value (head)
  );

  wrap_counter #(
    .DEPTH (DEPTH),
    .WIDTH (PTR_W)
  ) u_tail (
    .clock (clock),
    .reset (reset),
    .inc   (free_accept),
    .value (tail)
  );

  // Reset reloads the identity-mapped spare registers in ascending order.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= PHYS_ADDR_WIDTH'(ARCH_REGS + i);
      end
    end else if (free_accept) begin
      mem[tail] <= free_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= COUNT_FULL;
    end else begin
      case ({free_accept, alloc_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_error <= 1'b0;
    end else if (free_drop) begin
      overflow_error <= 1'b1;
    end
  end

endmodule
